// File: rtl/ff_fifo_pkg.sv
// Shared helpers for the level-tracking FIFO: occupancy-counter width and
// non-power-of-two pointer wrap.
package ff_fifo_pkg;

  function automatic int unsigned level_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

  // Wraps by explicit compare so any depth >= 2 works.
  function automatic int unsigned wrap_inc(input int unsigned ptr, input int unsigned depth);
    return (ptr == depth - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/ff_fifo_level_if.sv
// Handshake/status bundle for ff_fifo_level; master drives requests, slave is the FIFO.
interface ff_fifo_level_if
  import ff_fifo_pkg::*;
#(
  parameter int unsigned width = 5,
  parameter int unsigned depth = 6
);
  localparam int unsigned lvl_w = level_width(depth);

  logic             push;
  logic             pop;
  logic [width-1:0] write_data;
  logic [width-1:0] read_data;
  logic             empty;
  logic             full;
  logic             almost_empty;
  logic             almost_full;
  logic [lvl_w-1:0] level;
  logic             overflow;
  logic             underflow;

  modport master (
    output push, pop, write_data,
    input  read_data, empty, full, almost_empty, almost_full, level, overflow, underflow
  );

  modport slave (
    input  push, pop, write_data,
    output read_data, empty, full, almost_empty, almost_full, level, overflow, underflow
  );
endinterface

// File: rtl/ff_fifo_wrap_ptr.sv
// Read/write pointer counting 0..depth-1 with explicit wrap; synchronous active-high reset.
module ff_fifo_wrap_ptr
  import ff_fifo_pkg::*;
#(
  parameter int unsigned depth = 6
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     inc,
  output logic [$clog2(depth)-1:0] ptr
);
  localparam int unsigned ptr_w = $clog2(depth);

  logic [ptr_w-1:0] ptr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else if (inc) begin
      ptr_q <= ptr_w'(wrap_inc(32'(ptr_q), depth));
    end
  end

  assign ptr = ptr_q;
endmodule

// File: rtl/ff_fifo_level.sv
// Show-ahead synchronous FIFO with registered level and decoded status flags.
// Sticky overflow/underflow are built only when FF_FIFO_LEVEL_ERR_EN is defined.
module ff_fifo_level
  import ff_fifo_pkg::*;
#(
  parameter int unsigned width              = 5,
  parameter int unsigned depth              = 6,
  parameter int unsigned almost_full_level  = depth - 1,
  parameter int unsigned almost_empty_level = 1
) (
  input logic              clk,
  input logic              rst,
  ff_fifo_level_if.slave   bus
);
  localparam int unsigned lvl_w = level_width(depth);
  localparam int unsigned ptr_w = $clog2(depth);

  if (depth < 2) begin : g_chk_depth
    $error("ff_fifo_level: depth must be >= 2");
  end
  if (almost_full_level < 1 || almost_full_level > depth) begin : g_chk_af
    $error("ff_fifo_level: almost_full_level must be in 1..depth");
  end
  if (almost_empty_level >= depth) begin : g_chk_ae
    $error("ff_fifo_level: almost_empty_level must be < depth");
  end

  logic [width-1:0] mem [depth];
  logic [ptr_w-1:0] wr_ptr;
  logic [ptr_w-1:0] rd_ptr;
  logic [lvl_w-1:0] level_q;
  logic [lvl_w-1:0] level_d;
  logic             empty;
  logic             full;
  logic             push_acc;
  logic             pop_acc;

  assign empty = (level_q == '0);
  assign full  = (level_q == lvl_w'(depth));

  // A full FIFO still takes a push when a pop frees the head slot this edge.
  assign push_acc = bus.push && (!full || bus.pop);
  assign pop_acc  = bus.pop && !empty;

  always_comb begin
    level_d = level_q;
    case ({push_acc, pop_acc})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      level_q <= '0;
    end else begin
      level_q <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push_acc) begin
      mem[wr_ptr] <= bus.write_data;
    end
  end

  ff_fifo_wrap_ptr #(.depth(depth)) u_wr_ptr (
    .clk (clk),
    .rst (rst),
    .inc (push_acc),
    .ptr (wr_ptr)
  );

  ff_fifo_wrap_ptr #(.depth(depth)) u_rd_ptr (
    .clk (clk),
    .rst (rst),
    .inc (pop_acc),
    .ptr (rd_ptr)
  );

  assign bus.read_data    = mem[rd_ptr];
  assign bus.empty        = empty;
  assign bus.full         = full;
  assign bus.level        = level_q;
  assign bus.almost_empty = (level_q <= lvl_w'(almost_empty_level));
  assign bus.almost_full  = (level_q >= lvl_w'(almost_full_level));

`ifdef FF_FIFO_LEVEL_ERR_EN
  logic overflow_q;
  logic underflow_q;

  // push+pop on full and push+pop on empty are legal and never flag an error.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (bus.push && full && !bus.pop) overflow_q <= 1'b1;
      if (bus.pop && empty && !bus.push) underflow_q <= 1'b1;
    end
  end

  assign bus.overflow  = overflow_q;
  assign bus.underflow = underflow_q;
`else
  assign bus.overflow  = 1'b0;
  assign bus.underflow = 1'b0;
`endif
endmodule

// File: tb/tb_ff_fifo_level.sv
// Scoreboard bench for ff_fifo_level (depth 6, width 5); expected overflow/underflow
// follow whether FF_FIFO_LEVEL_ERR_EN is defined for the build.
module tb_ff_fifo_level;
  localparam int unsigned Width = 5;
  localparam int unsigned Depth = 6;
`ifdef FF_FIFO_LEVEL_ERR_EN
  localparam int ErrEn = 1;
`else
  localparam int ErrEn = 0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;

  ff_fifo_level_if #(.width(Width), .depth(Depth)) bus ();

  ff_fifo_level #(
    .width              (Width),
    .depth              (Depth),
    .almost_full_level  (Depth - 1),
    .almost_empty_level (1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;
  int m_level     = 0;
  logic [Width-1:0] exp_q[$];

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every accepted pop must present the oldest outstanding word.
  always @(negedge clk) begin
    if (!rst && bus.pop && !bus.empty) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL pop_data: got 0x%0h, expected no accepted pop", bus.read_data);
      end else begin
        logic [Width-1:0] e;
        e = exp_q.pop_front();
        if (bus.read_data !== e) begin
          miscompares++;
          $display("FAIL pop_data: got 0x%0h, expected 0x%0h", bus.read_data, e);
        end
      end
    end
  end

  // Drives one cycle starting at posedge+1; returns at the next posedge+1.
  task automatic cycle(input bit p, input bit q, input logic [Width-1:0] d);
    bit push_ok;
    bit pop_ok;
    push_ok = p && (m_level < Depth || q);
    pop_ok  = q && (m_level > 0);
    bus.push = p;
    bus.pop = q;
    bus.write_data = d;
    if (push_ok) exp_q.push_back(d);
    m_level = m_level + int'(push_ok) - int'(pop_ok);
    @(posedge clk);
    #1;
    bus.push = 1'b0;
    bus.pop = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    m_level = 0;
  endtask

  task automatic chk_idle_flags(input string tag);
    chk({tag, "_level"}, int'(bus.level), 0);
    chk({tag, "_empty"}, int'(bus.empty), 1);
    chk({tag, "_full"}, int'(bus.full), 0);
    chk({tag, "_aempty"}, int'(bus.almost_empty), 1);
    chk({tag, "_afull"}, int'(bus.almost_full), 0);
    chk({tag, "_ovf"}, int'(bus.overflow), 0);
    chk({tag, "_unf"}, int'(bus.underflow), 0);
  endtask

  initial begin
    bus.push = 1'b0;
    bus.pop = 1'b0;
    bus.write_data = '0;
    @(posedge clk);
    #1;
    do_reset();
    chk_idle_flags("reset");

    // Fill to full, watching thresholds at each level.
    for (int i = 1; i <= 6; i++) begin
      cycle(1'b1, 1'b0, Width'(i));
      chk($sformatf("fill%0d_level", i), int'(bus.level), i);
      chk($sformatf("fill%0d_afull", i), int'(bus.almost_full), int'(i >= 5));
      chk($sformatf("fill%0d_aempty", i), int'(bus.almost_empty), int'(i <= 1));
      chk($sformatf("fill%0d_full", i), int'(bus.full), int'(i == 6));
    end
    cycle(1'b1, 1'b0, 5'h07);
    chk("reject_level", int'(bus.level), 6);
    chk("reject_full", int'(bus.full), 1);
    chk("reject_ovf", int'(bus.overflow), ErrEn);

    // Simultaneous push/pop on full.
    do_reset();
    for (int i = 1; i <= 6; i++) cycle(1'b1, 1'b0, Width'(i));
    cycle(1'b1, 1'b1, 5'h1F);
    chk("fullpp_level", int'(bus.level), 6);
    chk("fullpp_head", int'(bus.read_data), 2);
    chk("fullpp_ovf", int'(bus.overflow), 0);
    for (int i = 0; i < 6; i++) cycle(1'b0, 1'b1, '0);
    chk("drain_empty", int'(bus.empty), 1);
    chk("drain_qsize", exp_q.size(), 0);

    // Push-then-pop pairs across several pointer wraps.
    for (int i = 0; i < 20; i++) begin
      cycle(1'b1, 1'b0, Width'(i));
      chk($sformatf("pair%0d_show", i), int'(bus.read_data), i);
      cycle(1'b0, 1'b1, '0);
    end
    chk("pairs_empty", int'(bus.empty), 1);
    chk("pairs_level", int'(bus.level), 0);

    // Simultaneous push/pop on empty, then a lone pop on empty.
    cycle(1'b1, 1'b1, 5'h0A);
    chk("emptypp_level", int'(bus.level), 1);
    chk("emptypp_data", int'(bus.read_data), 'h0A);
    chk("emptypp_unf", int'(bus.underflow), 0);
    cycle(1'b0, 1'b1, '0);
    chk("pop_last_empty", int'(bus.empty), 1);
    cycle(1'b0, 1'b1, '0);
    chk("underflow", int'(bus.underflow), ErrEn);
    chk("underflow_level", int'(bus.level), 0);

    // Reset wins over a held push at level 3.
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, Width'(5'h10 + i));
    chk("pre_rst_level", int'(bus.level), 3);
    bus.push = 1'b1;
    bus.write_data = 5'h15;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.push = 1'b0;
    exp_q.delete();
    m_level = 0;
    chk_idle_flags("rst_push");
    cycle(1'b0, 1'b0, '0);
    chk_idle_flags("post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish, expected finish before 100000");
    $fatal(1);
  end
endmodule

// File: doc/ff_fifo_level.md
FF_FIFO_LEVEL -- requirements
Module: ff_fifo_level

Interface
REQ-001 The block SHALL have the parameter: width, 5, data word width in bits (>=1).
REQ-002 The block SHALL have the parameter: depth, 6, number of storage entries (any integer >=2, not restricted to powers of two).
REQ-003 The block SHALL have the parameter: almost_full_level, depth-1, level at or above which almost_full asserts (1..depth).
REQ-004 The block SHALL have the parameter: almost_empty_level, 1, level at or below which almost_empty asserts (0..depth-1).
REQ-005 The block SHALL have the port: clk  input  1  single clock; all state changes on rising edge.
REQ-006 The block SHALL have the port: rst  input  1  reset; synchronous, active-high.
REQ-007 The block SHALL have the port: push  input  1  write request.
REQ-008 The block SHALL have the port: pop  input  1  read request.
REQ-009 The block SHALL have the port: write_data  input  width  data written on accepted push.
REQ-010 The block SHALL have the port: read_data  output  width  head entry, show-ahead (combinational from storage); don't-care while empty.
REQ-011 The block SHALL have the port: empty  output  1  level == 0.
REQ-012 The block SHALL have the port: full  output  1  level == depth.
REQ-013 The block SHALL have the port: almost_empty  output  1  level <= almost_empty_level.
REQ-014 The block SHALL have the port: almost_full  output  1  level >= almost_full_level.
REQ-015 The block SHALL have the port: level  output  $clog2(depth+1)  current occupancy.
REQ-016 The block SHALL have the port: overflow  output  1  sticky error, push rejected while full (see Configuration).
REQ-017 The block SHALL have the port: underflow  output  1  sticky error, pop rejected while empty (see Configuration).

Function
REQ-018 A push SHALL be accepted when push && (!full || pop); the accepted word is written at wr_ptr and wr_ptr advances in the same edge.
REQ-019 A pop SHALL be accepted when pop && !empty; rd_ptr advances, and the popped word is the read_data value visible before that edge.
REQ-020 Pointers SHALL run 0..depth-1 and wrap from depth-1 to 0 (explicit compare, no power-of-two masking).
REQ-021 level SHALL be +1 on push-only accept, -1 on pop-only accept, and unchanged on both-accept or neither.
REQ-022 On push+pop when full: both SHALL be accepted, level stays depth, and no overflow is raised.
REQ-023 On push+pop when empty: only the push SHALL be accepted, level becomes 1, and no underflow is raised.
REQ-024 All status flags SHALL be combinational decodes of the registered level, with zero-cycle latency from the level update.
REQ-025 Push-to-read_data latency SHALL be 1 cycle: a word pushed into an empty FIFO appears on read_data after the next edge.
REQ-026 Rejected requests SHALL NOT modify pointers, level or storage.

Reset
REQ-027 On rst=1 at a clock edge, wr_ptr, rd_ptr and level SHALL go to 0; empty=1, full=0, almost_empty=1, almost_full=0, overflow=0, underflow=0.
REQ-028 Reset SHALL have priority over simultaneous push/pop, and any data held at reset SHALL be discarded.
REQ-029 Storage contents SHALL NOT be reset.

Configuration
REQ-030 When the macro FF_FIFO_LEVEL_ERR_EN is defined, overflow SHALL set on a push rejected while full and underflow SHALL set on a pop rejected while empty; both are sticky until rst.
REQ-031 When FF_FIFO_LEVEL_ERR_EN is undefined, overflow and underflow SHALL be tied to 0 and no error registers are built; the port list is unchanged.

Structure
REQ-032 Package ff_fifo_pkg SHALL hold the level-width helper function (clog2 of depth+1) and the pointer-wrap increment function.
REQ-033 Pointer logic SHALL be a sub-module ff_fifo_wrap_ptr (parameter depth; inputs clk, rst, inc; output ptr), instantiated once for wr_ptr and once for rd_ptr.
REQ-034 Non-synthesis elaboration checks SHALL assert depth>=2, 1<=almost_full_level<=depth, and almost_empty_level<depth.

Verification
REQ-035 The bench SHALL cover: depth=6; after rst, push 6 words 0x01..0x06 -> full=1, level=6, almost_full=1 from level 5; 7th push rejected, level stays 6, overflow=1 (with macro).
REQ-036 The bench SHALL cover: depth=6; 20 push-then-pop pairs, data 0x00..0x13 -> read order matches push order across pointer wrap at 5->0; empty=1 at end.
REQ-037 The bench SHALL cover: full FIFO plus simultaneous push 0x1F/pop -> head popped, 0x1F at tail, level=6, overflow stays 0.
REQ-038 The bench SHALL cover: empty FIFO plus simultaneous push 0x0A/pop -> level=1, read_data=0x0A next cycle, underflow stays 0; then a lone pop on empty -> underflow=1.
REQ-039 The bench SHALL cover: level=3 with push held, assert rst one cycle -> level=0, empty=1, all error flags 0 on the following cycle.
REQ-040 The bench SHALL cover: rebuild without FF_FIFO_LEVEL_ERR_EN and repeat REQ-035 -> overflow stays 0.
